onehot_encoder8x3_seq: RTL

- Sequential 8-to-3 encoder; the inverse of the team's 3x8 address decoder.
- Accepts an 8-bit pattern over a valid/ready handshake.
- Serialises every set bit into a stream of 3-bit addresses, one per accepted output beat, lowest index first.
- Used where a decoded select or request vector must be turned back into addresses, e.g. a self-checking loop behind the 3x8 decoder.

---
 rtl/decoder_pkg.sv | 19 +
 rtl/priority_pick8.sv | 38 +++
 rtl/onehot_encoder8x3_seq.sv | 95 +++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | decoder_pkg: shared constants and encoder FSM state type.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package decoder_pkg;

    localparam int DEC_WIDTH  = 8;
    localparam int DEC_ADDR_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/priority_pick8.sv
// +----------------------------------------------------------------------------+
// | priority_pick8: index of the lowest (or highest, MSB_FIRST_ORDER_EN) set   |
// | bit of a vector, plus a flag telling whether exactly one bit is set.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module priority_pick8
    import decoder_pkg::*;
#(
    parameter int WIDTH  = DEC_WIDTH,
    parameter int ADDR_W = DEC_ADDR_W
) (
    input  logic [WIDTH-1:0]  i_vec,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_single
);

    // The last set bit visited wins, so the loop runs opposite to the
    // desired priority. An all-zero vector yields index 0.
    always_comb begin
        o_idx = '0;
`ifdef MSB_FIRST_ORDER_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_idx = ADDR_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = ADDR_W'(i);
        end
`endif
    end

    assign o_single = (i_vec != '0) && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/onehot_encoder8x3_seq.sv
// +----------------------------------------------------------------------------+
// | onehot_encoder8x3_seq: serialises each set bit of an 8-bit pattern into a  |
// | stream of 3-bit addresses. Build option: MSB_FIRST_ORDER_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module onehot_encoder8x3_seq
    import decoder_pkg::*;
#(
    parameter int WIDTH  = DEC_WIDTH,
    parameter int ADDR_W = DEC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_pattern,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_address,
    output logic              out_last,
    output logic              zero_err
);

    enc_state_t        r_state;
    enc_state_t        w_state_nxt;
    logic [WIDTH-1:0]  r_pending;
    logic [WIDTH-1:0]  w_pending_nxt;
    logic              r_zero_err;
    logic              w_zero_err_nxt;
    logic [ADDR_W-1:0] w_idx;
    logic              w_single;
    logic [WIDTH-1:0]  w_pick_mask;
    logic              w_emit;

    priority_pick8 #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_pick (
        .i_vec    (r_pending),
        .o_idx    (w_idx),
        .o_single (w_single)
    );

    assign w_pick_mask = WIDTH'(1) << w_idx;
    assign w_emit      = (r_state == EMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_zero_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_zero_err <= w_zero_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_zero_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (in_pattern != '0) begin
                        w_pending_nxt = in_pattern;
                        w_state_nxt   = EMIT;
                    end else begin
                        w_zero_err_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~w_pick_mask;
                    if (w_single) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Address is forced to zero outside EMIT so idle outputs never leak stale data.
    assign in_ready    = !w_emit;
    assign out_valid   = w_emit;
    assign out_address = w_emit ? w_idx : '0;
    assign out_last    = w_emit && w_single;
    assign zero_err    = r_zero_err;

endmodule

`default_nettype wire
